// File: rtl/dll_disc_pkg.sv
// Shared definitions for the multi-channel DLL discriminator: FSM encoding,
// default and derived widths, and the correction direction encoding.
package dll_disc_pkg;

    localparam int IQ_WIDTH_DEF    = 19;
    localparam int OP_WIDTH_DEF    = 8;
    localparam int SCALE_WIDTH_DEF = 16;

    // Derived widths at the default parameter set.
    localparam int QW          = OP_WIDTH_DEF + SCALE_WIDTH_DEF;
    localparam int PRE_WIDTH   = IQ_WIDTH_DEF + 1;
    localparam int INDEX_WIDTH = $clog2(PRE_WIDTH);

    localparam logic DPHI_DIR_FWD = 1'b0;
    localparam logic DPHI_DIR_REV = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_NORM,
        S_MULT,
        S_DIV,
        S_OUT
    } state_t;

endpackage

// File: rtl/dll_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. A start with a zero
// denominator is refused and flagged; done is high during the final iteration.
module dll_seq_divider #(
    parameter int NUM_WIDTH = 24,
    parameter int DEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_WIDTH-1:0] num,
    input  logic [DEN_WIDTH-1:0] den,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [NUM_WIDTH-1:0] quotient
);
    localparam int CNT_W = $clog2(NUM_WIDTH + 1);

    logic [DEN_WIDTH-1:0] den_r;
    logic [DEN_WIDTH-1:0] rem;
    logic [DEN_WIDTH-1:0] rem_nx;
    logic [DEN_WIDTH:0]   trial;
    logic                 fits;
    logic [CNT_W-1:0]     cnt;
    logic                 busy;

    // The quotient register doubles as the numerator shift register.
    always_comb begin
        trial  = {rem, quotient[NUM_WIDTH-1]};
        fits   = (trial >= {1'b0, den_r});
        rem_nx = fits ? DEN_WIDTH'(trial - {1'b0, den_r}) : trial[DEN_WIDTH-1:0];
    end

    assign div_by_zero = start && (den == '0);
    assign done        = busy && (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            den_r    <= '0;
            rem      <= '0;
            quotient <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
        end else if (start && (den != '0)) begin
            den_r    <= den;
            rem      <= '0;
            quotient <= num;
            cnt      <= CNT_W'(NUM_WIDTH);
            busy     <= 1'b1;
        end else if (busy) begin
            rem      <= rem_nx;
            quotient <= {quotient[NUM_WIDTH-2:0], fits};
            cnt      <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/dll_disc_mc.sv
// Shared DLL discriminator: queues per-channel early/late requests and returns
// a tagged, saturated code-phase correction, normalised or unnormalised.
module dll_disc_mc
    import dll_disc_pkg::*;
#(
    parameter int IQ_WIDTH    = 19,
    parameter int OP_WIDTH    = 8,
    parameter int SCALE_WIDTH = 16,
    parameter int SCALE       = 4096,
    parameter int SCALE_SHIFT = 8,
    parameter int DPHI_WIDTH  = 12,
    parameter int TAG_WIDTH   = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [TAG_WIDTH-1:0]  tag,
    input  logic                  mode,
    input  logic [IQ_WIDTH-1:0]   iq_early,
    input  logic [IQ_WIDTH-1:0]   iq_late,
    output logic                  full,
    output logic                  overflow,
    output logic                  result_ready,
    output logic [TAG_WIDTH-1:0]  result_tag,
    output logic [DPHI_WIDTH-1:0] delta_phase_increment,
    output logic                  zero_sum
);
    localparam int Q_W = OP_WIDTH + SCALE_WIDTH;
    localparam int P_W = IQ_WIDTH + 1;
    localparam int I_W = $clog2(P_W);
    localparam int E_W = TAG_WIDTH + 1 + 2 * IQ_WIDTH;
    localparam int A_W = $clog2(FIFO_DEPTH);
    localparam int C_W = A_W + 1;
    localparam logic [SCALE_WIDTH-1:0] K    = SCALE_WIDTH'(SCALE);
    localparam logic [DPHI_WIDTH-1:0]  DMAX = {1'b0, {(DPHI_WIDTH-1){1'b1}}};

    function automatic logic [I_W-1:0] msb_idx(input logic [P_W-1:0] v);
        msb_idx = '0;
        for (int i = 0; i < P_W; i++)
            if (v[i]) msb_idx = I_W'(i);
    endfunction

    // ---------------- request FIFO ----------------
    logic [E_W-1:0] mem [FIFO_DEPTH];
    logic [A_W-1:0] wr_ptr, rd_ptr;
    logic [C_W-1:0] count;
    logic           push, pop;
    logic [E_W-1:0] head;
    state_t         state, state_nx;

    assign full = (count == C_W'(FIFO_DEPTH));
    assign push = start && !full;
    assign pop  = (state == S_IDLE) && (count != '0);
    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {tag, mode, iq_early, iq_late};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + A_W'(1);
            if (pop)  rd_ptr <= rd_ptr + A_W'(1);
            if (push && !pop)      count <= count + C_W'(1);
            else if (pop && !push) count <= count - C_W'(1);
            overflow <= start && full;
        end
    end

    // ---------------- datapath ----------------
    logic [TAG_WIDTH-1:0]  tag_r;
    logic                  mode_r, dir_r, zs_r;
    logic [IQ_WIDTH-1:0]   e_r, l_r;
    logic [P_W-1:0]        sum_r, diff_r, mx;
    logic [I_W-1:0]        idx, sh;
    logic [OP_WIDTH-1:0]   op_sum, op_diff, diff_sat;
    logic [Q_W-1:0]        p_r, prod, quotient, q_sel, r;
    logic [DPHI_WIDTH-1:0] mag, dphi_nx;
    logic                  div_start, div_done, div_zero;

    always_comb begin
        mx       = (sum_r >= diff_r) ? sum_r : diff_r;
        idx      = msb_idx(mx);
        sh       = (idx >= I_W'(OP_WIDTH)) ? idx - I_W'(OP_WIDTH - 1) : '0;
        diff_sat = (diff_r[P_W-1:OP_WIDTH] != '0) ? '1 : diff_r[OP_WIDTH-1:0];
        prod     = Q_W'(op_diff) * Q_W'(K);
        q_sel    = mode_r ? (zs_r ? '0 : quotient) : p_r;
        r        = q_sel >> SCALE_SHIFT;
        mag      = (r > Q_W'(DMAX)) ? DMAX : r[DPHI_WIDTH-1:0];
        dphi_nx  = (dir_r == DPHI_DIR_REV) ? -mag : mag;
    end

    assign div_start = (state == S_MULT) && mode_r;

    dll_seq_divider #(
        .NUM_WIDTH (Q_W),
        .DEN_WIDTH (OP_WIDTH)
    ) u_div (
        .clk         (clk),
        .rst         (reset),
        .start       (div_start),
        .num         (prod),
        .den         (op_sum),
        .done        (div_done),
        .div_by_zero (div_zero),
        .quotient    (quotient)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (count != '0) state_nx = S_LOAD;
            S_LOAD: state_nx = S_NORM;
            S_NORM: state_nx = S_MULT;
            S_MULT: state_nx = (mode_r && !div_zero) ? S_DIV : S_OUT;
            S_DIV:  if (div_done) state_nx = S_OUT;
            S_OUT:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_r <= '0; mode_r <= 1'b0; e_r <= '0; l_r <= '0;
            sum_r <= '0; diff_r <= '0; dir_r <= DPHI_DIR_FWD;
            op_sum <= '0; op_diff <= '0; p_r <= '0; zs_r <= 1'b0;
            result_ready <= 1'b0; result_tag <= '0;
            delta_phase_increment <= '0; zero_sum <= 1'b0;
        end else begin
            result_ready <= 1'b0;
            if (pop) {tag_r, mode_r, e_r, l_r} <= head;
            case (state)
                S_LOAD: begin
                    sum_r <= {1'b0, e_r} + {1'b0, l_r};
                    if (e_r < l_r) begin
                        diff_r <= {1'b0, l_r} - {1'b0, e_r};
                        dir_r  <= DPHI_DIR_REV;
                    end else begin
                        diff_r <= {1'b0, e_r} - {1'b0, l_r};
                        dir_r  <= DPHI_DIR_FWD;
                    end
                end
                S_NORM: begin
                    // Shift keeps the ratio while fitting both into OP_WIDTH bits.
                    op_sum  <= mode_r ? OP_WIDTH'(sum_r >> sh) : '0;
                    op_diff <= mode_r ? OP_WIDTH'(diff_r >> sh) : diff_sat;
                end
                S_MULT: begin
                    p_r  <= prod;
                    zs_r <= mode_r && div_zero;
                end
                S_OUT: begin
                    result_ready          <= 1'b1;
                    result_tag            <= tag_r;
                    delta_phase_increment <= dphi_nx;
                    zero_sum              <= zs_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dll_disc_mc.sv
// Bench for dll_disc_mc: directed and random requests checked by a queue
// scoreboard against an arithmetic reference model of the discriminator.
module tb_dll_disc_mc;
    import dll_disc_pkg::*;

    localparam int IQ_WIDTH    = 19;
    localparam int OP_WIDTH    = 8;
    localparam int SCALE_WIDTH = 16;
    localparam int SCALE       = 4096;
    localparam int SCALE_SHIFT = 8;
    localparam int DPHI_WIDTH  = 12;
    localparam int TAG_WIDTH   = 4;
    localparam int FIFO_DEPTH  = 4;
    localparam int EXP_W       = TAG_WIDTH + DPHI_WIDTH + 1;
    localparam int LAT_SHORT   = 5;
    localparam int LAT_DIV     = 5 + QW;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  mode;
    logic [IQ_WIDTH-1:0]   iq_early, iq_late;
    logic                  full, overflow, result_ready, zero_sum;
    logic [TAG_WIDTH-1:0]  result_tag;
    logic [DPHI_WIDTH-1:0] delta_phase_increment;

    logic [EXP_W-1:0] exp_q[$];
    int               lat_q[$];
    int               issue_q[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               rr_seen;

    dll_disc_mc #(
        .IQ_WIDTH(IQ_WIDTH), .OP_WIDTH(OP_WIDTH), .SCALE_WIDTH(SCALE_WIDTH),
        .SCALE(SCALE), .SCALE_SHIFT(SCALE_SHIFT), .DPHI_WIDTH(DPHI_WIDTH),
        .TAG_WIDTH(TAG_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .tag(tag), .mode(mode),
        .iq_early(iq_early), .iq_late(iq_late), .full(full), .overflow(overflow),
        .result_ready(result_ready), .result_tag(result_tag),
        .delta_phase_increment(delta_phase_increment), .zero_sum(zero_sum)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Returns {zero_sum, dphi} straight from the arithmetic definition.
    function automatic logic [DPHI_WIDTH:0] model(input bit m, input int e, input int l);
        longint s, d, q, r;
        bit zs;
        logic [DPHI_WIDTH-1:0] v;
        zs = 1'b0;
        d  = (e > l) ? longint'(e - l) : longint'(l - e);
        if (m) begin
            s = longint'(e) + longint'(l);
            if (s == 0) begin
                q  = 0;
                zs = 1'b1;
            end else begin
                while (s >= (longint'(1) << OP_WIDTH)) begin
                    s = s / 2;
                    d = d / 2;
                end
                q = (d * SCALE) / s;
            end
        end else begin
            if (d > (1 << OP_WIDTH) - 1) d = (1 << OP_WIDTH) - 1;
            q = d * SCALE;
        end
        r = q >> SCALE_SHIFT;
        if (r > (1 << (DPHI_WIDTH - 1)) - 1) r = (1 << (DPHI_WIDTH - 1)) - 1;
        if (l > e) r = -r;
        v = r[DPHI_WIDTH-1:0];
        return {zs, v};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Called just after a clock edge; the request is sampled on the next edge.
    task automatic issue(input logic [TAG_WIDTH-1:0] t, input bit m, input int e,
                         input int l, input bit accept, input bit timed);
        start    = 1'b1;
        tag      = t;
        mode     = m;
        iq_early = e[IQ_WIDTH-1:0];
        iq_late  = l[IQ_WIDTH-1:0];
        if (accept) begin
            exp_q.push_back({t, model(m, e, l)});
            issue_q.push_back(cyc + 1);
            if (!timed)                    lat_q.push_back(-1);
            else if (m && (e + l != 0))    lat_q.push_back(LAT_DIV);
            else                           lat_q.push_back(LAT_SHORT);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d results pending expected 0", exp_q.size());
            exp_q.delete(); lat_q.delete(); issue_q.delete();
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        int lat, t0;
        if (!reset && result_ready) begin
            rr_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got tag=%0d dphi=%0d expected none",
                         result_tag, $signed(delta_phase_increment));
            end else begin
                e   = exp_q.pop_front();
                lat = lat_q.pop_front();
                t0  = issue_q.pop_front();
                if ({result_tag, zero_sum, delta_phase_increment} !== e) begin
                    errors++;
                    $display("FAIL result: got tag=%0d zs=%0b dphi=%0d expected tag=%0d zs=%0b dphi=%0d",
                             result_tag, zero_sum, $signed(delta_phase_increment),
                             e[EXP_W-1 -: TAG_WIDTH], e[DPHI_WIDTH],
                             $signed(e[DPHI_WIDTH-1:0]));
                end
                if (lat >= 0) begin
                    checks++;
                    if (cyc - t0 != lat) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles expected %0d", cyc - t0, lat);
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int e, l;
        bit m;
        rr_seen = 0;
        reset = 1'b1; start = 1'b0; tag = '0; mode = 1'b0; iq_early = '0; iq_late = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result_ready", 32'(result_ready), 32'd0);
        chk("reset_outputs", 32'({result_tag, delta_phase_increment, zero_sum}), 32'd0);
        chk("reset_full_overflow", 32'({full, overflow}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases from the arithmetic definition.
        issue(4'd3, 1'b1, 300, 100, 1'b1, 1'b1);   drain(60);
        issue(4'd4, 1'b1, 100, 300, 1'b1, 1'b1);   drain(60);
        issue(4'd5, 1'b0, 150, 100, 1'b1, 1'b1);   drain(60);
        issue(4'd6, 1'b0, 5000, 0, 1'b1, 1'b1);    drain(60);
        issue(4'd7, 1'b0, 0, 5000, 1'b1, 1'b1);    drain(60);
        chk("sat_neg_hold", 32'(delta_phase_increment), 32'h801);
        issue(4'd1, 1'b1, 0, 0, 1'b1, 1'b1);       drain(60);
        chk("zero_sum_hold", 32'(zero_sum), 32'd1);
        issue(4'd2, 1'b1, 7, 7, 1'b1, 1'b1);       drain(60);
        chk("equal_zs_clear", 32'(zero_sum), 32'd0);

        // FIFO fill and overflow while a divide is in progress.
        issue(4'd8, 1'b1, 300, 100, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            issue(TAG_WIDTH'(i), 1'b1, 1000 + 37 * i, 200 + 11 * i, i < FIFO_DEPTH, 1'b0);
            chk($sformatf("full_%0d", i), 32'(full), 32'(i >= FIFO_DEPTH - 1));
            chk($sformatf("overflow_%0d", i), 32'(overflow), 32'(i >= FIFO_DEPTH));
        end
        @(posedge clk); #1;
        chk("overflow_clear", 32'(overflow), 32'd0);
        drain(300);

        // Reset ten cycles into a divide, with a second request queued.
        issue(4'd10, 1'b1, 300, 100, 1'b1, 1'b1);
        issue(4'd11, 1'b0, 150, 100, 1'b1, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete(); lat_q.delete(); issue_q.delete();
        #1;
        chk("midreset_outputs", 32'({result_ready, result_tag, delta_phase_increment, zero_sum}), 32'd0);
        chk("midreset_full_overflow", 32'({full, overflow}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rr_seen = 0;
        repeat (40) @(posedge clk);
        #1;
        chk("no_result_after_reset", 32'(rr_seen), 32'd0);
        issue(4'd12, 1'b0, 150, 100, 1'b1, 1'b1);  drain(60);

        // Randomized traffic, kept within FIFO capacity.
        for (int n = 0; n < 150; n++) begin
            int w;
            w = 0;
            while (exp_q.size() >= FIFO_DEPTH && w < 200) begin
                @(posedge clk); #1;
                w++;
            end
            m = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: begin e = int'($urandom_range(0, (1 << IQ_WIDTH) - 1));
                         l = int'($urandom_range(0, (1 << IQ_WIDTH) - 1)); end
                1: begin e = int'($urandom_range(0, 300)); l = int'($urandom_range(0, 300)); end
                2: begin e = int'($urandom_range(0, (1 << IQ_WIDTH) - 1)); l = e; end
                default: begin e = int'($urandom_range(0, 9000)); l = 0;
                               if ($urandom_range(0, 1) == 1) begin l = e; e = 0; end end
            endcase
            issue(TAG_WIDTH'($urandom_range(0, 15)), m, e, l, 1'b1, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
        end
        drain(FIFO_DEPTH * 40 + 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
